// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the 8-bit accumulator CPU.
//   opcode_t : the eight ISA opcodes, shared by the controller and the ALU
//   phase_t  : the eight phases of one machine cycle
//   ctrl_t   : the datapath strobes driven by the controller
//   is_aluop : true for opcodes that load the accumulator from the ALU
package cpu_pkg;

    typedef enum logic [2:0] {
        OP_HLT = 3'b000,
        OP_SKZ = 3'b001,
        OP_ADD = 3'b010,
        OP_AND = 3'b011,
        OP_XOR = 3'b100,
        OP_LDA = 3'b101,
        OP_STO = 3'b110,
        OP_JMP = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_t;

    typedef struct packed {
        logic sel;
        logic rd;
        logic ld_ir;
        logic inc_pc;
        logic ld_pc;
        logic ld_ac;
        logic wr;
        logic data_e;
    } ctrl_t;

    // Opcodes whose result goes through the ALU into the accumulator.
    function automatic logic is_aluop(opcode_t op);
        return (op == OP_ADD) || (op == OP_AND) ||
               (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/cpu_controller.sv
// cpu_controller
// Instruction sequencer for the 8-bit accumulator CPU. Steps a fixed
// 8-phase machine cycle and decodes the per-phase datapath strobes.
// Ports:
//   clk     in   clock, all state changes on the rising edge
//   rst_n   in   synchronous active-low reset
//   en      in   phase-advance enable (0 holds phase and outputs)
//   opcode  in   3-bit opcode from the instruction register
//   is_zero in   ALU zero flag, used by SKZ in the ALU_OP phase
//   sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e
//           out  datapath strobes
//   halt    out  CPU halted (sticky until reset), rises early in OP_ADDR
//   phase   out  current phase index 0..7
module cpu_controller
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] opcode,
    input  logic       is_zero,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       ld_ac,
    output logic       wr,
    output logic       data_e,
    output logic       halt,
    output logic [2:0] phase
);

    // State: current phase plus a halted flag. While halted the phase
    // register is parked at OP_ADDR, so phase reads 4.
    phase_t  phase_q, phase_d;
    logic    halted_q, halted_d;

    opcode_t op;
    logic    alu_op;
    ctrl_t   ctrl;
    logic    halt_d;
    logic [2:0] phase_inc;

    assign op        = opcode_t'(opcode);
    assign alu_op    = is_aluop(op);
    assign phase_inc = phase_q + 3'd1;

    // Strobe decode: purely combinational from the phase, the live opcode
    // and the zero flag. Everything is forced low once halted.
    always_comb begin
        ctrl   = '0;
        halt_d = halted_q;
        if (!halted_q) begin
            case (phase_q)
                PH_INST_ADDR: begin
                    ctrl.sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    ctrl.sel = 1'b1;
                    ctrl.rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    ctrl.sel   = 1'b1;
                    ctrl.rd    = 1'b1;
                    ctrl.ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    ctrl.inc_pc = 1'b1;
                    // halt is visible one cycle before HALTED is entered
                    halt_d      = (op == OP_HLT);
                end
                PH_OP_FETCH: begin
                    ctrl.rd = alu_op;
                end
                PH_ALU_OP: begin
                    ctrl.rd     = alu_op;
                    ctrl.inc_pc = (op == OP_SKZ) && is_zero;
                    ctrl.ld_pc  = (op == OP_JMP);
                    ctrl.data_e = (op == OP_STO);
                end
                PH_STORE: begin
                    ctrl.rd     = alu_op;
                    ctrl.ld_ac  = alu_op;
                    ctrl.ld_pc  = (op == OP_JMP);
                    ctrl.wr     = (op == OP_STO);
                    ctrl.data_e = (op == OP_STO);
                end
                default: begin
                    ctrl = '0;
                end
            endcase
        end
    end

    // Next-state logic. A halted flag with the phase anywhere other than
    // OP_ADDR can only come from a corrupted state, so it recovers to the
    // start of a fresh instruction instead of staying stuck.
    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        if (halted_q) begin
            if (phase_q != PH_OP_ADDR) begin
                phase_d  = PH_INST_ADDR;
                halted_d = 1'b0;
            end
        end else if (en) begin
            if ((phase_q == PH_OP_ADDR) && (op == OP_HLT)) begin
                halted_d = 1'b1;
            end else begin
                phase_d = phase_t'(phase_inc);
            end
        end
    end

    // State register with synchronous reset; reset wins over en.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q  <= PH_INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    assign sel    = ctrl.sel;
    assign rd     = ctrl.rd;
    assign ld_ir  = ctrl.ld_ir;
    assign inc_pc = ctrl.inc_pc;
    assign ld_pc  = ctrl.ld_pc;
    assign ld_ac  = ctrl.ld_ac;
    assign wr     = ctrl.wr;
    assign data_e = ctrl.data_e;
    assign halt   = halt_d;
    assign phase  = phase_q;

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller
// Table-driven bench for cpu_controller. Each vector holds the inputs for
// one rising edge and the outputs expected just after that edge.
// Strobe vector order: {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e}.
module tb_cpu_controller;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] opcode;
    logic       is_zero;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e;
    logic       halt;
    logic [2:0] phase;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [2:0] opcode;
        logic       is_zero;
        logic [2:0] exp_phase;
        logic [7:0] exp_ctrl;
        logic       exp_halt;
        string      name;
    } vec_t;

    vec_t vecs[$];

    localparam logic [2:0] HLT = 3'b000;
    localparam logic [2:0] SKZ = 3'b001;
    localparam logic [2:0] ADD = 3'b010;
    localparam logic [2:0] STO = 3'b110;
    localparam logic [2:0] JMP = 3'b111;

    cpu_controller dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .opcode  (opcode),
        .is_zero (is_zero),
        .sel     (sel),
        .rd      (rd),
        .ld_ir   (ld_ir),
        .inc_pc  (inc_pc),
        .ld_pc   (ld_pc),
        .ld_ac   (ld_ac),
        .wr      (wr),
        .data_e  (data_e),
        .halt    (halt),
        .phase   (phase)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVec(input logic r, input logic e, input logic [2:0] op,
                          input logic iz, input logic [2:0] ph,
                          input logic [7:0] c, input logic h, input string n);
        vec_t v;
        v.rst_n = r; v.en = e; v.opcode = op; v.is_zero = iz;
        v.exp_phase = ph; v.exp_ctrl = c; v.exp_halt = h; v.name = n;
        vecs.push_back(v);
    endtask

    // Drive inputs away from the edge, then let one rising edge pass.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst_n   = v.rst_n;
        en      = v.en;
        opcode  = v.opcode;
        is_zero = v.is_zero;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        logic [7:0] c;
        c = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e};
        tests_run++;
        if (phase !== v.exp_phase || c !== v.exp_ctrl || halt !== v.exp_halt) begin
            tests_failed++;
            $display("[TB] FAIL %s #%0d: got phase=%0d ctrl=%b halt=%b, want phase=%0d ctrl=%b halt=%b",
                     v.name, idx, phase, c, halt, v.exp_phase, v.exp_ctrl, v.exp_halt);
        end
    endtask

    // Standard instruction fetch: phases 1..4 after leaving phase 0.
    task automatic addFetch(input logic [2:0] op, input logic iz, input string n);
        addVec(1, 1, op, iz, 3'd1, 8'b1100_0000, 0, n);
        addVec(1, 1, op, iz, 3'd2, 8'b1110_0000, 0, n);
        addVec(1, 1, op, iz, 3'd3, 8'b1110_0000, 0, n);
        addVec(1, 1, op, iz, 3'd4, 8'b0001_0000, op == HLT, n);
    endtask

    task automatic addAdd(input string n);
        addFetch(ADD, 0, n);
        addVec(1, 1, ADD, 0, 3'd5, 8'b0100_0000, 0, n);
        addVec(1, 1, ADD, 0, 3'd6, 8'b0100_0000, 0, n);
        addVec(1, 1, ADD, 0, 3'd7, 8'b0100_0100, 0, n);
        addVec(1, 1, ADD, 0, 3'd0, 8'b1000_0000, 0, n);
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0; en = 1'b0; opcode = ADD; is_zero = 1'b0;

        // Reset state
        addVec(0, 1, ADD, 0, 3'd0, 8'b1000_0000, 0, "reset");
        // ADD full instruction
        addAdd("add");
        // SKZ with zero flag set: extra inc_pc at phase 6
        addFetch(SKZ, 1, "skz_z1");
        addVec(1, 1, SKZ, 1, 3'd5, 8'b0000_0000, 0, "skz_z1");
        addVec(1, 1, SKZ, 1, 3'd6, 8'b0001_0000, 0, "skz_z1");
        addVec(1, 1, SKZ, 1, 3'd7, 8'b0000_0000, 0, "skz_z1");
        addVec(1, 1, SKZ, 1, 3'd0, 8'b1000_0000, 0, "skz_z1");
        // SKZ with zero flag clear
        addFetch(SKZ, 0, "skz_z0");
        addVec(1, 1, SKZ, 0, 3'd5, 8'b0000_0000, 0, "skz_z0");
        addVec(1, 1, SKZ, 0, 3'd6, 8'b0000_0000, 0, "skz_z0");
        addVec(1, 1, SKZ, 0, 3'd7, 8'b0000_0000, 0, "skz_z0");
        addVec(1, 1, SKZ, 0, 3'd0, 8'b1000_0000, 0, "skz_z0");
        // STO: data_e at 6..7, wr at 7, no rd
        addFetch(STO, 0, "sto");
        addVec(1, 1, STO, 0, 3'd5, 8'b0000_0000, 0, "sto");
        addVec(1, 1, STO, 0, 3'd6, 8'b0000_0001, 0, "sto");
        addVec(1, 1, STO, 0, 3'd7, 8'b0000_0011, 0, "sto");
        addVec(1, 1, STO, 0, 3'd0, 8'b1000_0000, 0, "sto");
        // JMP with en dropped for two cycles at phase 6
        addFetch(JMP, 0, "jmp");
        addVec(1, 1, JMP, 0, 3'd5, 8'b0000_0000, 0, "jmp");
        addVec(1, 1, JMP, 0, 3'd6, 8'b0000_1000, 0, "jmp");
        addVec(1, 0, JMP, 0, 3'd6, 8'b0000_1000, 0, "jmp_hold");
        addVec(1, 0, JMP, 0, 3'd6, 8'b0000_1000, 0, "jmp_hold");
        addVec(1, 1, JMP, 0, 3'd7, 8'b0000_1000, 0, "jmp");
        addVec(1, 1, JMP, 0, 3'd0, 8'b1000_0000, 0, "jmp");
        // Reset at phase 5 with en=1, then a clean ADD
        addFetch(ADD, 0, "midrst");
        addVec(1, 1, ADD, 0, 3'd5, 8'b0100_0000, 0, "midrst");
        addVec(0, 1, ADD, 0, 3'd0, 8'b1000_0000, 0, "midrst_reset");
        addAdd("after_rst");
        // HLT: halt early at phase 4, en=0 there must not enter HALTED
        addFetch(HLT, 0, "hlt");
        addVec(1, 0, HLT, 0, 3'd4, 8'b0001_0000, 1, "hlt_en0");
        addVec(1, 1, HLT, 0, 3'd4, 8'b0000_0000, 1, "halted");

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end

        // HALTED is sticky for 20 cycles whatever en, opcode and is_zero do.
        for (int i = 0; i < 20; i++) begin
            v.rst_n = 1'b1;
            v.en = 1'($urandom_range(0, 1));
            v.opcode = 3'($urandom_range(0, 7));
            v.is_zero = 1'($urandom_range(0, 1));
            v.exp_phase = 3'd4; v.exp_ctrl = 8'h00; v.exp_halt = 1'b1;
            v.name = "halt_sticky";
            applyStimulus(v);
            checkOutput(v, i);
        end

        // Only reset leaves HALTED.
        v.rst_n = 1'b0; v.en = 1'b1; v.opcode = HLT; v.is_zero = 1'b0;
        v.exp_phase = 3'd0; v.exp_ctrl = 8'b1000_0000; v.exp_halt = 1'b0;
        v.name = "halt_reset";
        applyStimulus(v);
        checkOutput(v, 0);

        // First phase step after leaving HALTED.
        v.rst_n = 1'b1; v.opcode = ADD;
        v.exp_phase = 3'd1; v.exp_ctrl = 8'b1100_0000; v.exp_halt = 1'b0;
        v.name = "post_halt_step";
        applyStimulus(v);
        checkOutput(v, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
